// File: rtl/logic_gates.sv
// Registered bitwise AND/OR/XOR unit with one-cycle latency and a valid flag.
// Define LOGIC_GATES_EXT_EN to add registered NAND/NOR/XNOR outputs.
module logic_gates #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_or,
    output logic [WIDTH-1:0] y_xor,
`ifdef LOGIC_GATES_EXT_EN
    output logic [WIDTH-1:0] y_nand,
    output logic [WIDTH-1:0] y_nor,
    output logic [WIDTH-1:0] y_xnor,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] and_q, or_q, xor_q;
    logic             valid_q;

    // Result registers only load on in_valid, so unknown operands on idle cycles never reach them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_q   <= '0;
            or_q    <= '0;
            xor_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                and_q <= a & b;
                or_q  <= a | b;
                xor_q <= a ^ b;
            end
        end
    end

    assign y_and     = and_q;
    assign y_or      = or_q;
    assign y_xor     = xor_q;
    assign out_valid = valid_q;

`ifdef LOGIC_GATES_EXT_EN
    logic [WIDTH-1:0] nand_q, nor_q, xnor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nand_q <= '0;
            nor_q  <= '0;
            xnor_q <= '0;
        end else if (in_valid) begin
            nand_q <= ~(a & b);
            nor_q  <= ~(a | b);
            xnor_q <= ~(a ^ b);
        end
    end

    assign y_nand = nand_q;
    assign y_nor  = nor_q;
    assign y_xnor = xnor_q;
`else
    // Base outputs only; no inverted-result registers are built.
`endif

endmodule

// File: tb/tb_logic_gates.sv
// Directed bench for logic_gates: one WIDTH=1 and one WIDTH=8 instance on a shared clock/reset.
module tb_logic_gates;

    logic       clk;
    logic       rst_n;
    logic       iv1, iv8;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;
    logic [0:0] and1, or1, xor1;
    logic [7:0] and8, or8, xor8;
    logic       ov1, ov8;
`ifdef LOGIC_GATES_EXT_EN
    logic [0:0] nand1, nor1, xnor1;
    logic [7:0] nand8, nor8, xnor8;
`endif

    int checks = 0;
    int fails  = 0;

    logic_gates #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv1),
        .a        (a1),
        .b        (b1),
        .y_and    (and1),
        .y_or     (or1),
        .y_xor    (xor1),
`ifdef LOGIC_GATES_EXT_EN
        .y_nand   (nand1),
        .y_nor    (nor1),
        .y_xnor   (xnor1),
`endif
        .out_valid(ov1)
    );

    logic_gates #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv8),
        .a        (a8),
        .b        (b8),
        .y_and    (and8),
        .y_or     (or8),
        .y_xor    (xor8),
`ifdef LOGIC_GATES_EXT_EN
        .y_nand   (nand8),
        .y_nor    (nor8),
        .y_xnor   (xnor8),
`endif
        .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #12;
        checks++;
        if ({and1, or1, xor1, ov1, and8, or8, xor8, ov8} !== 28'h0) begin
            fails++;
            $display("FAIL reset_initial got %b want all zero",
                     {and1, or1, xor1, ov1, and8, or8, xor8, ov8});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({and1, or1, xor1, ov1} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_idle_after_release got %b want 0000", {and1, or1, xor1, ov1});
        end
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({and1, or1, xor1, ov1} !== 4'b0111) begin
            fails++;
            $display("FAIL reset_prefill got %b want 0111", {and1, or1, xor1, ov1});
        end
        iv1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({and1, or1, xor1, ov1} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async got %b want 0000", {and1, or1, xor1, ov1});
        end
`ifdef LOGIC_GATES_EXT_EN
        checks++;
        if ({nand1, nor1, xnor1} !== 3'b000) begin
            fails++;
            $display("FAIL reset_async_ext got %b want 000", {nand1, nor1, xnor1});
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [1:0] ab;
        logic [3:0] exp_and, exp_or, exp_xor;
        exp_and = 4'b1000;
        exp_or  = 4'b1110;
        exp_xor = 4'b0110;
        iv1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1];
            b1 = ab[0];
            @(posedge clk); #1;
            checks++;
            if ({and1, or1, xor1, ov1} !== {exp_and[i], exp_or[i], exp_xor[i], 1'b1}) begin
                fails++;
                $display("FAIL truth_ab%b got and/or/xor/ov=%b want %b", ab,
                         {and1, or1, xor1, ov1}, {exp_and[i], exp_or[i], exp_xor[i], 1'b1});
            end
`ifdef LOGIC_GATES_EXT_EN
            checks++;
            if ({nand1, nor1, xnor1} !== ~{exp_and[i], exp_or[i], exp_xor[i]}) begin
                fails++;
                $display("FAIL truth_ext_ab%b got %b want %b", ab, {nand1, nor1, xnor1},
                         ~{exp_and[i], exp_or[i], exp_xor[i]});
            end
`endif
        end
    endtask

    task automatic test_hold();
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({and1, ov1} !== 2'b11) begin
            fails++;
            $display("FAIL hold_load got and/ov=%b want 11", {and1, ov1});
        end
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                a1 = 1'bx; b1 = 1'bz;
            end
            @(posedge clk); #1;
            checks++;
            if ({and1, or1, xor1, ov1} !== 4'b1100) begin
                fails++;
                $display("FAIL hold_edge%0d got and/or/xor/ov=%b want 1100", i,
                         {and1, or1, xor1, ov1});
            end
        end
        a1 = 1'b0; b1 = 1'b0;
    endtask

    task automatic test_wide();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] e_and [4];
        logic [7:0] e_or [4];
        logic [7:0] e_xor [4];
        va = '{8'hF0, 8'hAA, 8'h81, 8'hFF};
        vb = '{8'h3C, 8'h55, 8'hC3, 8'h00};
        e_and = '{8'h30, 8'h00, 8'h81, 8'h00};
        e_or  = '{8'hFC, 8'hFF, 8'hC3, 8'hFF};
        e_xor = '{8'hCC, 8'hFF, 8'h42, 8'hFF};
        iv8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a8 = va[i];
            b8 = vb[i];
            @(posedge clk); #1;
            checks++;
            if ({and8, or8, xor8, ov8} !== {e_and[i], e_or[i], e_xor[i], 1'b1}) begin
                fails++;
                $display("FAIL wide_%0d got and=%h or=%h xor=%h ov=%b want %h %h %h 1", i,
                         and8, or8, xor8, ov8, e_and[i], e_or[i], e_xor[i]);
            end
        end
`ifdef LOGIC_GATES_EXT_EN
        a8 = 8'hF0; b8 = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if ({nand8, nor8, xnor8} !== {8'hCF, 8'h03, 8'h33}) begin
            fails++;
            $display("FAIL wide_ext got nand=%h nor=%h xnor=%h want cf 03 33",
                     nand8, nor8, xnor8);
        end
`endif
        // Operands change with no clock edge: outputs must not follow.
        iv8 = 1'b0;
        a8 = 8'h0F; b8 = 8'hFF;
        #2;
        checks++;
        if ({and8, or8, xor8} === {8'h0F, 8'hFF, 8'hF0} || ov8 !== 1'b1) begin
            fails++;
            $display("FAIL wide_no_comb_path got and=%h or=%h xor=%h ov=%b", and8, or8, xor8, ov8);
        end
    endtask

    task automatic test_reset_midstream();
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        iv8 = 1'b1; a8 = 8'h81; b8 = 8'hC3;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({and1, or1, xor1, ov1, and8, or8, xor8, ov8} !== 28'h0) begin
            fails++;
            $display("FAIL midstream_reset got %b want all zero",
                     {and1, or1, xor1, ov1, and8, or8, xor8, ov8});
        end
        // A valid edge while held in reset must not load anything.
        @(posedge clk); #1;
        checks++;
        if ({and1, or1, xor1, ov1, and8, or8, xor8, ov8} !== 28'h0) begin
            fails++;
            $display("FAIL midstream_held got %b want all zero",
                     {and1, or1, xor1, ov1, and8, or8, xor8, ov8});
        end
        rst_n = 1'b1;
        iv1 = 1'b0; iv8 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({and1, or1, xor1, ov1, and8, or8, xor8, ov8} !== 28'h0) begin
            fails++;
            $display("FAIL midstream_idle got %b want all zero",
                     {and1, or1, xor1, ov1, and8, or8, xor8, ov8});
        end
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({and1, or1, xor1, ov1} !== 4'b0111) begin
            fails++;
            $display("FAIL midstream_first_valid got and/or/xor/ov=%b want 0111",
                     {and1, or1, xor1, ov1});
        end
        iv1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_wide();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
